log_lut_controller: RTL

LOG_LUT_CONTROLLER -- requirements
Module: log_lut_controller

---
 rtl/log_lut_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/log_lut_controller.sv
// Purpose: log-curve pixel mapper; a reloadable LUT (2^ADDR_W x DATA_W) maps linear codes to output pixels, with an MSB-truncating bypass until a curve is loaded.
// Latency: one cycle from the pixel handshake to out_valid (one output register stage, memory read is that register).
// Backpressure: in_ready drops while a result is held with out_ready=0; a reload first drains that result, then accepts cfg entries at one per cycle.
//
// Ports:
//   sys_clk, sys_rst            clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   linear pixel code stream
//   out_data/out_valid/out_ready mapped pixel stream
//   cfg_start                   one-cycle reload request
//   cfg_data/cfg_valid/cfg_ready curve entries, written in address order 0..2^ADDR_W-1
//   lut_loaded                  a complete curve is resident and mapping is active
//   load_count                  completed loads, modulo 256
module log_lut_controller #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [ADDR_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cfg_start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              lut_loaded,
    output logic [7:0]        load_count
);

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic              sel_q, sel_d;          // 1: current result came from the LUT
    logic [DATA_W-1:0] byp_q, byp_d;
    logic              lut_loaded_q, lut_loaded_d;
    logic [7:0]        load_count_q, load_count_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    logic              accept_ok;
    logic              in_fire;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;

    // Pixels only flow in BYPASS/RUN; a reload request blocks the pixel in
    // the same cycle so nothing is in flight once DRAIN is entered.
    assign accept_ok = sys_rst
                     && ((state_q == ST_BYPASS) || (state_q == ST_RUN))
                     && !cfg_start
                     && (!out_valid_q || out_ready);
    assign in_ready  = accept_ok;
    assign in_fire   = in_valid && accept_ok;
    assign cfg_ready = sys_rst && (state_q == ST_LOAD);

    // A cfg beat coinciding with a restart is dropped, not written.
    assign mem_we   = cfg_valid && cfg_ready && !cfg_start;
    assign mem_re   = in_fire && (state_q == ST_RUN);
    assign mem_addr = mem_we ? ptr_q : in_data;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lut_loaded_d = lut_loaded_q;
        load_count_d = load_count_q;
        out_valid_d  = out_valid_q;
        sel_d        = sel_q;
        byp_d        = byp_q;

        case (state_q)
            ST_BYPASS, ST_RUN: begin
                if (cfg_start) begin
                    state_d      = ST_DRAIN;
                    lut_loaded_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                // The held result leaves (or there is none) on this edge.
                if (!out_valid_q || out_ready) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    ptr_d = '0;
                end else if (cfg_valid) begin
                    ptr_d = ADDR_W'(ptr_q + 1'b1);
                    if (ptr_q == {ADDR_W{1'b1}}) begin
                        state_d      = ST_RUN;
                        lut_loaded_d = 1'b1;
                        load_count_d = load_count_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_BYPASS;
        endcase

        if (in_fire) begin
            out_valid_d = 1'b1;
            sel_d       = (state_q == ST_RUN);
            byp_d       = in_data[ADDR_W-1 -: DATA_W];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q      <= ST_BYPASS;
            ptr_q        <= '0;
            out_valid_q  <= 1'b0;
            sel_q        <= 1'b0;
            byp_q        <= '0;
            lut_loaded_q <= 1'b0;
            load_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            sel_q        <= sel_d;
            byp_q        <= byp_d;
            lut_loaded_q <= lut_loaded_d;
            load_count_q <= load_count_d;
        end
    end

    // Single-port memory: write and read are exclusive by state. rd_q only
    // updates on a RUN accept, so it holds the result during a stall.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[mem_addr] <= cfg_data;
        end else if (mem_re) begin
            rd_q <= mem[mem_addr];
        end
    end

    assign out_data   = sel_q ? rd_q : byp_q;
    assign out_valid  = out_valid_q;
    assign lut_loaded = lut_loaded_q;
    assign load_count = load_count_q;

endmodule
